regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter N, default 64: data width in bits.
REQ-002 Parameter REGS, default 32: number of registers, a power of two, at least 4.
REQ-003 Parameter ZERO_REG, default REGS-1: index that always reads 0 and ignores writes.
REQ-004 Parameter BYPASS, default 1: when 1, a same-cycle write is forwarded to the read ports.
REQ-005 AW = $clog2(REGS) is the address width and SHALL be derived from REGS, not a separate parameter.
REQ-006 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 we3  in  1  write enable.
REQ-009 wa3  in  AW  write address.
REQ-010 wd3  in  N  write data.
REQ-011 ra1, ra2  in  AW each  read addresses.
REQ-012 rd1, rd2  out  N each  read data.
REQ-013 alloc  in  1  reserve a destination register as pending.
REQ-014 alloc_a  in  AW  register to reserve.
REQ-015 busy1, busy2  out  1 each  pending status of ra1 and ra2.
REQ-016 wr_err  out  1  registered flag: the last accepted write hit a non-pending register.
REQ-017 pend_cnt  out  AW+1  number of registers currently pending.

Function
REQ-018 Storage SHALL be REGS words of N bits, plus one busy bit per register.
REQ-019 Write: on a rising edge with we3=1 and wa3!=ZERO_REG, mem[wa3] SHALL take wd3 and busy[wa3] SHALL clear.
REQ-020 Any write to ZERO_REG SHALL be dropped: no storage change, busy unchanged, wr_err not raised.
REQ-021 Reads SHALL be combinational: rdX = 0 if raX==ZERO_REG, else mem[raX].
REQ-022 With BYPASS=1, we3=1 and wa3==raX!=ZERO_REG, rdX SHALL equal wd3 in the same cycle.
REQ-023 With BYPASS=0, the new value SHALL appear only after the write edge.
REQ-024 Alloc: on a rising edge with alloc=1 and alloc_a!=ZERO_REG, busy[alloc_a] SHALL set.
REQ-025 An alloc to ZERO_REG SHALL be ignored.
REQ-026 Same-edge write and alloc to the same register: the data SHALL be written and busy SHALL end set (alloc wins).
REQ-027 Same-edge write and alloc to different registers: both SHALL take effect independently.
REQ-028 busyX = busy[raX], except it SHALL be 0 for ZERO_REG.
REQ-029 With BYPASS=1, busyX SHALL also be 0 when the same-cycle write targets raX and no same-cycle alloc targets raX.
REQ-030 wr_err SHALL update on every edge with we3=1: 1 if wa3!=ZERO_REG and busy[wa3] was 0 before the edge, else 0.
REQ-031 wr_err SHALL hold its value on edges with we3=0.
REQ-032 A write flagged by wr_err SHALL still store its data.
REQ-033 pend_cnt SHALL equal the population count of busy after each edge and SHALL never exceed REGS-1.
REQ-034 pend_cnt SHALL be maintained as a registered counter: +1, -1 or 0 per edge.
REQ-035 Re-alloc of an already-busy register SHALL leave pend_cnt unchanged.

Reset
REQ-036 reset=0 SHALL asynchronously clear every mem word, every busy bit, wr_err and pend_cnt to 0, without waiting for a clock edge.
REQ-037 While reset=0, writes and allocs SHALL be ignored, and rd1, rd2, busy1, busy2 SHALL read 0.
REQ-038 Reset asserted between edges mid-operation SHALL discard any pending writes and allocs.
REQ-039 The first edge after reset deasserts SHALL operate normally.

Verification
REQ-040 Reset, then ra1=0..REGS-1 -> every rd1=0, busy1=0, pend_cnt=0.
REQ-041 alloc a=10; next edge write wa3=10, wd3=64'hFFFF_FFFF_FFFF_FFFF; ra1=10, ra2=11 -> before the write edge busy1=1 and, with BYPASS=1, rd1=FFFF_FFFF_FFFF_FFFF; after the write edge busy1=0, rd2=0, wr_err=0, pend_cnt=0.
REQ-042 Write wa3=31, wd3=5 with ZERO_REG=31, ra1=31 -> rd1=0, wr_err=0; alloc 31 -> pend_cnt stays 0.
REQ-043 Write wa3=3 with no prior alloc -> wr_err=1 after the edge and mem[3] updated; an idle edge follows -> wr_err still 1.
REQ-044 Same edge: alloc a=7 and write wa3=7, wd3=0x55 -> rd(7)=0x55, busy(7)=1, pend_cnt=1.
REQ-045 Alloc registers 0..4, assert reset mid-cycle -> busy, pend_cnt and mem clear immediately; repeat with BYPASS=0 -> same-cycle read of the written register returns the old value.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with per-register pending (scoreboard) bits, optional write-to-read
// forwarding, a write-to-idle-register error flag and a registered pending counter.
module regfile_sb #(
    parameter int N        = 64,
    parameter int REGS     = 32,
    parameter int ZERO_REG = REGS - 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we3,
    input  logic [AW-1:0] wa3,
    input  logic [N-1:0]  wd3,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [N-1:0]  rd1,
    output logic [N-1:0]  rd2,
    input  logic          alloc,
    input  logic [AW-1:0] alloc_a,
    output logic          busy1,
    output logic          busy2,
    output logic          wr_err,
    output logic [AW:0]   pend_cnt
);

    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

    logic [N-1:0]    mem [REGS];
    logic [REGS-1:0] busy;
    logic [REGS-1:0] busy_nxt;
    logic            wr_v;
    logic            al_v;
    logic            inc;
    logic            dec;

    assign wr_v = we3 && (wa3 != ZR);
    assign al_v = alloc && (alloc_a != ZR);

    // A same-edge alloc to the written register keeps it pending, so it only
    // counts as a decrement when the alloc targets a different register.
    assign inc = al_v && !busy[alloc_a];
    assign dec = wr_v && busy[wa3] && !(al_v && (alloc_a == wa3));

    always_comb begin
        busy_nxt = busy;
        if (wr_v) busy_nxt[wa3] = 1'b0;
        if (al_v) busy_nxt[alloc_a] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REGS; i++) mem[i] <= '0;
            busy     <= '0;
            wr_err   <= 1'b0;
            pend_cnt <= '0;
        end else begin
            if (wr_v) mem[wa3] <= wd3;
            busy <= busy_nxt;
            if (we3) wr_err <= wr_v && !busy[wa3];
            pend_cnt <= pend_cnt + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
        end
    end

    // Outputs are forced to zero while reset is held so forwarding cannot leak wd3.
    always_comb begin
        rd1   = '0;
        busy1 = 1'b0;
        if (reset && (ra1 != ZR)) begin
            rd1   = mem[ra1];
            busy1 = busy[ra1];
            if ((BYPASS != 0) && we3 && (wa3 == ra1)) begin
                rd1 = wd3;
                if (!(alloc && (alloc_a == ra1))) busy1 = 1'b0;
            end
        end
    end

    always_comb begin
        rd2   = '0;
        busy2 = 1'b0;
        if (reset && (ra2 != ZR)) begin
            rd2   = mem[ra2];
            busy2 = busy[ra2];
            if ((BYPASS != 0) && we3 && (wa3 == ra2)) begin
                rd2 = wd3;
                if (!(alloc && (alloc_a == ra2))) busy2 = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (forwarding on/off) sharing stimulus, checked
// against an array-based model every cycle plus directed literal checks.
module tb_regfile_sb;

    localparam int N    = 64;
    localparam int REGS = 32;
    localparam int AW   = 5;
    localparam int ZR   = 31;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          we3 = 1'b0;
    logic          alloc = 1'b0;
    logic [AW-1:0] wa3 = '0;
    logic [AW-1:0] ra1 = '0;
    logic [AW-1:0] ra2 = '0;
    logic [AW-1:0] alloc_a = '0;
    logic [N-1:0]  wd3 = '0;

    logic [N-1:0]  rd1_a, rd2_a, rd1_b, rd2_b;
    logic          busy1_a, busy2_a, busy1_b, busy2_b;
    logic          wr_err_a, wr_err_b;
    logic [AW:0]   pend_a, pend_b;

    int vectors = 0;
    int miscompares = 0;

    regfile_sb #(.N(N), .REGS(REGS), .ZERO_REG(ZR), .BYPASS(1)) dut_byp (
        .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
        .alloc(alloc), .alloc_a(alloc_a), .busy1(busy1_a), .busy2(busy2_a),
        .wr_err(wr_err_a), .pend_cnt(pend_a)
    );

    regfile_sb #(.N(N), .REGS(REGS), .ZERO_REG(ZR), .BYPASS(0)) dut_nobyp (
        .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
        .alloc(alloc), .alloc_a(alloc_a), .busy1(busy1_b), .busy2(busy2_b),
        .wr_err(wr_err_b), .pend_cnt(pend_b)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: plain arrays updated by the architectural rules.
    logic [N-1:0] mem_m [REGS];
    bit           busy_m [REGS];
    bit           err_m = 1'b0;

    initial begin
        foreach (mem_m[i]) begin
            mem_m[i]  = '0;
            busy_m[i] = 1'b0;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            foreach (mem_m[i]) begin
                mem_m[i]  = '0;
                busy_m[i] = 1'b0;
            end
            err_m = 1'b0;
        end else begin
            if (we3) err_m = (int'(wa3) != ZR) && !busy_m[wa3];
            if (we3 && int'(wa3) != ZR) begin
                mem_m[wa3]  = wd3;
                busy_m[wa3] = 1'b0;
            end
            if (alloc && int'(alloc_a) != ZR) busy_m[alloc_a] = 1'b1;
        end
    end

    function automatic int pend_m();
        int c = 0;
        foreach (busy_m[i]) c += int'(busy_m[i]);
        return c;
    endfunction

    function automatic logic [N-1:0] exp_rd(input logic [AW-1:0] ra, input bit byp);
        if (!reset || int'(ra) == ZR) return '0;
        if (byp && we3 && wa3 == ra) return wd3;
        return mem_m[ra];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] ra, input bit byp);
        if (!reset || int'(ra) == ZR) return 1'b0;
        if (byp && we3 && wa3 == ra && !(alloc && alloc_a == ra)) return 1'b0;
        return busy_m[ra];
    endfunction

    // Inputs change at negedge+1; compare runs at negedge+6, before the next rising edge.
    always begin
        @(negedge clk);
        #6;
        chk("rd1_byp",    rd1_a,    exp_rd(ra1, 1'b1));
        chk("rd2_byp",    rd2_a,    exp_rd(ra2, 1'b1));
        chk("busy1_byp",  N'(busy1_a), N'(exp_busy(ra1, 1'b1)));
        chk("busy2_byp",  N'(busy2_a), N'(exp_busy(ra2, 1'b1)));
        chk("rd1_nobyp",  rd1_b,    exp_rd(ra1, 1'b0));
        chk("rd2_nobyp",  rd2_b,    exp_rd(ra2, 1'b0));
        chk("busy1_nobyp", N'(busy1_b), N'(exp_busy(ra1, 1'b0)));
        chk("busy2_nobyp", N'(busy2_b), N'(exp_busy(ra2, 1'b0)));
        chk("wr_err_byp", N'(wr_err_a), N'(err_m));
        chk("wr_err_nobyp", N'(wr_err_b), N'(err_m));
        chk("pend_byp",   N'(pend_a), N'(pend_m()));
        chk("pend_nobyp", N'(pend_b), N'(pend_m()));
    end

    task automatic drive(input bit we, input int wa, input logic [N-1:0] wd,
                         input int r1, input int r2, input bit al, input int aa);
        @(negedge clk);
        #1;
        we3     = we;
        wa3     = AW'(wa);
        wd3     = wd;
        ra1     = AW'(r1);
        ra2     = AW'(r2);
        alloc   = al;
        alloc_a = AW'(aa);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    int wa, aa, r1, r2, sel;
    bit we, al;

    initial begin
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;

        // Fresh state reads zero everywhere.
        for (int r = 0; r < REGS; r++) begin
            drive(0, 0, '0, r, 0, 0, 0);
            #1;
            chk("reset_rd1", rd1_a, '0);
            chk("reset_busy1", N'(busy1_a), '0);
            chk("reset_pend", N'(pend_a), '0);
        end

        // Alloc 10, then write it with all ones.
        drive(0, 0, '0, 10, 11, 1, 10);
        after_edge();
        chk("alloc10_busy", N'(busy1_a), 1);
        chk("alloc10_pend", N'(pend_a), 1);
        drive(1, 10, '1, 10, 11, 0, 0);
        #1;
        chk("pre_busy_nobyp", N'(busy1_b), 1);
        chk("pre_rd_byp", rd1_a, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("pre_rd_nobyp", rd1_b, '0);
        after_edge();
        chk("post_busy", N'(busy1_a), 0);
        chk("post_rd2", rd2_a, '0);
        chk("post_wr_err", N'(wr_err_a), 0);
        chk("post_pend", N'(pend_a), 0);
        chk("post_rd_nobyp", rd1_b, 64'hFFFF_FFFF_FFFF_FFFF);

        // Zero register ignores writes and allocs.
        drive(1, 31, 64'd5, 31, 0, 0, 0);
        after_edge();
        chk("zr_rd", rd1_a, '0);
        chk("zr_wr_err", N'(wr_err_a), 0);
        drive(0, 0, '0, 31, 0, 1, 31);
        after_edge();
        chk("zr_alloc_pend", N'(pend_a), 0);

        // Write to an idle register flags an error but still stores.
        drive(1, 3, 64'h1234, 3, 0, 0, 0);
        after_edge();
        chk("err_set", N'(wr_err_a), 1);
        chk("err_data", rd1_a, 64'h1234);
        drive(0, 0, '0, 3, 0, 0, 0);
        after_edge();
        chk("err_hold", N'(wr_err_a), 1);

        // Same-edge write and alloc to 7: alloc wins.
        drive(1, 7, 64'h55, 7, 0, 1, 7);
        after_edge();
        chk("same_rd", rd1_a, 64'h55);
        chk("same_busy", N'(busy1_a), 1);
        chk("same_pend", N'(pend_a), 1);

        // Alloc 0..4, then mid-cycle reset.
        drive(1, 2, 64'h11, 2, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, '0, i, 0, 1, i);
        after_edge();
        chk("alloc5_pend", N'(pend_a), 6);
        drive(1, 2, 64'hAA, 2, 4, 0, 0);
        #1;
        chk("old_rd_nobyp", rd1_b, 64'h11);
        chk("new_rd_byp", rd1_a, 64'hAA);
        #1 reset = 1'b0;
        #1;
        chk("rst_pend", N'(pend_a), 0);
        chk("rst_busy2", N'(busy2_a), 0);
        chk("rst_rd1_byp", rd1_a, '0);
        chk("rst_rd1_nobyp", rd1_b, '0);
        @(negedge clk);
        #1;
        we3 = 1'b0;
        alloc = 1'b0;
        reset = 1'b1;
        drive(0, 0, '0, 2, 3, 0, 0);
        #1;
        chk("discard_rd", rd1_b, '0);
        chk("discard_rd3", rd2_b, '0);
        drive(1, 2, 64'h77, 2, 4, 1, 4);
        after_edge();
        chk("first_edge_rd", rd1_a, 64'h77);
        chk("first_edge_pend", N'(pend_a), 1);
        chk("first_edge_err", N'(wr_err_a), 1);

        // Randomised traffic with collisions biased in.
        for (int k = 0; k < 3000; k++) begin
            wa = ($urandom_range(0, 15) == 0) ? ZR : int'($urandom_range(0, REGS - 1));
            aa = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, REGS - 1));
            sel = $urandom_range(0, 3);
            r1 = (sel == 0) ? wa : (sel == 1) ? aa : int'($urandom_range(0, REGS - 1));
            sel = $urandom_range(0, 3);
            r2 = (sel == 0) ? wa : (sel == 1) ? aa : int'($urandom_range(0, REGS - 1));
            we = ($urandom_range(0, 1) == 1);
            al = ($urandom_range(0, 1) == 1);
            drive(we, wa, {$urandom, $urandom}, r1, r2, al, aa);
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                #1 reset = 1'b1;
            end
        end

        drive(0, 0, '0, 0, 0, 0, 0);
        after_edge();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
